// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: control inputs, instr_mem read port and decode handshake.
// master = instr_fetch, slave = whatever drives/consumes it (memory, decode, control).
interface instr_fetch_if #(
    parameter int INSTR_W = 30,
    parameter int PC_W    = 6,
    parameter int DEPTH   = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic               fetch_en;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    mem_pc;
    logic               mem_req;
    logic [INSTR_W-1:0] mem_instr;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [LVL_W-1:0]   level;

    modport master (
        input  fetch_en, redirect, redirect_pc, mem_instr, instr_ready,
        output mem_pc, mem_req, instr, instr_pc, instr_valid, level
    );

    modport slave (
        output fetch_en, redirect, redirect_pc, mem_instr, instr_ready,
        input  mem_pc, mem_req, instr, instr_pc, instr_valid, level
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, request issue to a 1-cycle instr_mem, response FIFO to decode.
// Optional macro INSTR_FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module instr_fetch #(
    parameter int INSTR_W = 30,
    parameter int PC_W    = 6,
    parameter int DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [PC_W-1:0]    tag_q  [DEPTH];

    logic               req;
    logic               push;
    logic               write;
    logic               pop;
    logic               fifo_empty;
    logic [LVL_W:0]     occupancy;

    // Counting the in-flight read reserves its slot, so a push can never overflow.
    assign occupancy  = {1'b0, level_q} + (LVL_W+1)'(inflight_q);
    assign req        = (state_q == RUN) && !bus.redirect && (occupancy < (LVL_W+1)'(DEPTH));
    assign push       = inflight_q && !bus.redirect;
    assign fifo_empty = (level_q == '0);

`ifdef INSTR_FETCH_BYPASS_EN
    logic bypass;
    assign bypass          = fifo_empty && push;
    assign bus.instr_valid = !fifo_empty || push;
    assign bus.instr       = !fifo_empty ? data_q[rptr_q] : (bypass ? bus.mem_instr : '0);
    assign bus.instr_pc    = !fifo_empty ? tag_q[rptr_q]  : (bypass ? req_pc_q      : '0);
    assign pop             = !fifo_empty && bus.instr_ready && !bus.redirect;
    assign write           = push && !(bypass && bus.instr_ready);
`else
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = !fifo_empty ? data_q[rptr_q] : '0;
    assign bus.instr_pc    = !fifo_empty ? tag_q[rptr_q]  : '0;
    assign pop             = !fifo_empty && bus.instr_ready && !bus.redirect;
    assign write           = push;
`endif

    assign bus.mem_pc  = pc_q;
    assign bus.mem_req = req;
    assign bus.level   = level_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;

        case (state_q)
            IDLE:    if (bus.fetch_en)  state_d = RUN;
            RUN:     if (!bus.fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (req) begin
            pc_d     = pc_q + 1'b1;
            req_pc_d = pc_q;
        end

        if (write) wptr_d = wptr_q + 1'b1;
        if (pop)   rptr_d = rptr_q + 1'b1;
        level_d = level_q + LVL_W'(write) - LVL_W'(pop);

        // Redirect flushes everything; the response arriving now is simply never written.
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            inflight_d = 1'b0;
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (write && !rst) begin
            data_q[wptr_q] <= bus.mem_instr;
            tag_q[wptr_q]  <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch (default build): directed per-cycle vector table plus a wrap/throughput run.
module tb_instr_fetch;
    localparam int INSTR_W = 30;
    localparam int PC_W    = 6;
    localparam int DEPTH   = 4;

    typedef struct {
        logic       rst;
        logic       fe;
        logic       red;
        logic [5:0] rpc;
        logic       rdy;
        logic       req;
        logic [5:0] mpc;
        logic       vld;
        logic [5:0] ipc;
        logic [2:0] lvl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    logic monEn  = 1'b0;

    instr_fetch_if #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    instr_fetch #(.INSTR_W(INSTR_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: word at address a is 0x100 + a, one cycle after the request.
    initial bus.mem_instr = '0;
    always @(posedge clk) begin
        if (bus.mem_req) bus.mem_instr <= 30'h100 + 30'(bus.mem_pc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Overflow guard: occupancy must never exceed the FIFO depth.
    always @(negedge clk) begin
        if (monEn) check("level_le_depth", 32'(bus.level <= 3'(DEPTH)), 32'd1);
    end

    function automatic vec_t mk(input logic r, input logic fe, input logic red, input logic [5:0] rpc,
                                input logic rdy, input logic req, input logic [5:0] mpc,
                                input logic vld, input logic [5:0] ipc, input logic [2:0] lvl);
        vec_t v;
        v.rst = r;   v.fe  = fe;  v.red = red; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.mpc = mpc; v.vld = vld; v.ipc = ipc; v.lvl = lvl;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst             = v.rst;
        bus.fetch_en    = v.fe;
        bus.redirect    = v.red;
        bus.redirect_pc = v.rpc;
        bus.instr_ready = v.rdy;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        logic [29:0] expInstr;
        expInstr = v.vld ? 30'h100 + 30'(v.ipc) : 30'h0;
        check({tag, ".mem_req"},     32'(bus.mem_req),     32'(v.req));
        check({tag, ".mem_pc"},      32'(bus.mem_pc),      32'(v.mpc));
        check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(v.vld));
        check({tag, ".instr_pc"},    32'(bus.instr_pc),    32'(v.ipc));
        check({tag, ".instr"},       32'(bus.instr),       32'(expInstr));
        check({tag, ".level"},       32'(bus.level),       32'(v.lvl));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        rst             = 1'b1;
        bus.fetch_en    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput(mk(1,0,0,0,0, 0,0,0,0,0), "reset");
        monEn = 1'b1;
        stepCycle();

        //              rst fe red rpc rdy | req mpc vld ipc lvl
        vecs.push_back(mk(0,1,0, 0,1, 0, 0,0, 0,0));  // c0  IDLE
        vecs.push_back(mk(0,1,0, 0,1, 1, 0,0, 0,0));  // c1  first request
        vecs.push_back(mk(0,1,0, 0,1, 1, 1,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,0, 1, 2,1, 0,1));  // c3  first valid, ready low
        vecs.push_back(mk(0,1,0, 0,0, 1, 3,1, 0,2));
        vecs.push_back(mk(0,1,0, 0,0, 0, 4,1, 0,3));  // level+inflight hits depth
        vecs.push_back(mk(0,1,0, 0,0, 0, 4,1, 0,4));
        vecs.push_back(mk(0,1,0, 0,0, 0, 4,1, 0,4));
        vecs.push_back(mk(0,1,0, 0,1, 0, 4,1, 0,4));  // c8  ready back
        vecs.push_back(mk(0,1,0, 0,1, 1, 4,1, 1,3));
        vecs.push_back(mk(0,1,0, 0,1, 1, 5,1, 2,2));
        vecs.push_back(mk(0,1,0, 0,1, 1, 6,1, 3,2));
        vecs.push_back(mk(0,1,0, 0,1, 1, 7,1, 4,2));  // pc 4 follows with no loss
        vecs.push_back(mk(0,1,0, 0,0, 1, 8,1, 5,2));
        vecs.push_back(mk(0,1,1,32,1, 0, 9,1, 5,3));  // c14 redirect, level 3 + inflight
        vecs.push_back(mk(0,1,0, 0,1, 1,32,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,1, 1,33,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,1, 1,34,1,32,1));  // N+3
        vecs.push_back(mk(0,1,0, 0,1, 1,35,1,33,1));
        vecs.push_back(mk(0,0,0, 0,1, 1,36,1,34,1));  // c19 fetch_en drops
        vecs.push_back(mk(0,0,0, 0,1, 0,37,1,35,1));
        vecs.push_back(mk(0,0,0, 0,1, 0,37,1,36,1));  // in-flight word delivered
        vecs.push_back(mk(0,0,0, 0,1, 0,37,0, 0,0));
        vecs.push_back(mk(0,0,0, 0,1, 0,37,0, 0,0));
        vecs.push_back(mk(0,1,1,62,1, 0,37,0, 0,0));  // c24 redirect from IDLE
        vecs.push_back(mk(0,1,0, 0,1, 1,62,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,1, 1,63,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,1, 1, 0,1,62,1));
        vecs.push_back(mk(0,1,0, 0,1, 1, 1,1,63,1));
        vecs.push_back(mk(0,1,0, 0,1, 1, 2,1, 0,1));  // PC wrap
        vecs.push_back(mk(0,1,0, 0,1, 1, 3,1, 1,1));
        vecs.push_back(mk(0,1,0, 0,0, 1, 4,1, 2,1));
        vecs.push_back(mk(1,1,0, 0,0, 1, 5,1, 2,2));  // c32 rst with level 2 + inflight
        vecs.push_back(mk(0,1,0, 0,1, 0, 0,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,1, 1, 0,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,1, 1, 1,0, 0,0));
        vecs.push_back(mk(0,1,0, 0,1, 1, 2,1, 0,1));
        vecs.push_back(mk(0,1,0, 0,1, 1, 3,1, 1,1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], $sformatf("c%0d", i));
            stepCycle();
        end

        // Sustained fetch from reset through the top of PC space: one word per cycle, no gaps.
        rst             = 1'b1;
        bus.fetch_en    = 1'b0;
        bus.redirect    = 1'b0;
        bus.instr_ready = 1'b1;
        stepCycle();
        rst          = 1'b0;
        bus.fetch_en = 1'b1;
        for (int k = 0; k < 73; k++) begin
            @(negedge clk);
            if (k < 3) begin
                check($sformatf("run%0d.instr_valid", k), 32'(bus.instr_valid), 32'd0);
            end else begin
                check($sformatf("run%0d.instr_valid", k), 32'(bus.instr_valid), 32'd1);
                check($sformatf("run%0d.instr_pc", k), 32'(bus.instr_pc), 32'((k - 3) % 64));
                check($sformatf("run%0d.instr", k), 32'(bus.instr), 32'(32'h100 + 32'((k - 3) % 64)));
            end
            if (k >= 1) check($sformatf("run%0d.mem_req", k), 32'(bus.mem_req), 32'd1);
            stepCycle();
        end

        monEn = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
